// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl: execution controller for the 4-bit TD4 CPU.
//
// This module owns the 16x8 program memory. It shares that memory between CPU
// instruction fetch and an external program loader. It sequences the CPU through
// a one-cycle register-update enable (cpu_en) and a CPU reset (cpu_reset), and it
// provides halt, run (at a divided rate), single-step and restart control.
//
// Optional feature: define BREAKPOINT_EN to add a single address breakpoint.
// The breakpoint adds the ports bp_enable, bp_addr and bp_hit.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   run_req      in   1-cycle pulse: HALT -> RUN
//   halt_req     in   1-cycle pulse: any -> HALT
//   step_req     in   1-cycle pulse: HALT -> execute one instruction
//   restart_req  in   1-cycle pulse: pulse cpu_reset, end in HALT
//   rate         in   RUN tick period minus 1 (0 = every cycle)
//   cpu_address  in   CPU fetch address
//   cpu_data     out  mem[cpu_address], combinational read
//   cpu_en       out  CPU register-update enable, one cycle per instruction
//   cpu_reset    out  CPU synchronous reset
//   ld_valid     in   loader write request
//   ld_addr      in   loader write address
//   ld_data      in   loader write data
//   ld_ready     out  loader may write this cycle
//   bp_enable    in   (BREAKPOINT_EN) breakpoint armed
//   bp_addr      in   (BREAKPOINT_EN) breakpoint address
//   bp_hit       out  (BREAKPOINT_EN) 1-cycle pulse when RUN stops on bp_addr
//   halted       out  state == HALT
//
// state   | meaning
// HALT    | idle; loader owns memory, waits for run/step/restart
// RUN     | free-running, cpu_en once every rate+1 cycles
// STEP    | single cycle with cpu_en=1, then HALT
// RESTART | single cycle with cpu_reset=1, then HALT
module td4_exec_ctrl #(
  parameter int RATE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              restart_req,
  input  logic [RATE_W-1:0] rate,
  input  logic [3:0]        cpu_address,
  output logic [7:0]        cpu_data,
  output logic              cpu_en,
  output logic              cpu_reset,
  input  logic              ld_valid,
  input  logic [3:0]        ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
`ifdef BREAKPOINT_EN
  input  logic              bp_enable,
  input  logic [3:0]        bp_addr,
  output logic              bp_hit,
`endif
  output logic              halted
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_RESTART} state_t;

  state_t            state, state_nxt;
  logic [RATE_W-1:0] cnt, cnt_nxt;
  logic              tick_due;
  logic              en_raw;
  logic              bp_stop;
  logic              bp_block;
  logic [7:0]        mem [16];

`ifdef BREAKPOINT_EN
  logic bp_skip;

  // bp_skip lets a resumed RUN execute the instruction it stopped on.
  assign bp_block = bp_enable & (cpu_address == bp_addr) & ~bp_skip;

  always_ff @(posedge clock) begin
    if (reset)
      bp_skip <= 1'b0;
    else if (state == S_HALT && state_nxt == S_RUN)
      bp_skip <= 1'b1;
    else if (state == S_RUN && tick_due)
      bp_skip <= 1'b0;
  end

  assign bp_hit = bp_stop & ~reset;
`else
  assign bp_block = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tick_due  = 1'b0;
    en_raw    = 1'b0;
    bp_stop   = 1'b0;
    case (state)
      S_HALT: begin
        if (restart_req)   state_nxt = S_RESTART;
        else if (step_req) state_nxt = S_STEP;
        else if (run_req) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // The compare is >= so that lowering rate below cnt ticks at once.
        tick_due = (cnt >= rate);
        if (tick_due) begin
          cnt_nxt = '0;
          if (bp_block) bp_stop = 1'b1;
          else          en_raw  = 1'b1;
        end else begin
          cnt_nxt = cnt + RATE_W'(1);
        end
        if (restart_req)             state_nxt = S_RESTART;
        else if (halt_req || bp_stop) state_nxt = S_HALT;
      end
      S_STEP: begin
        en_raw    = 1'b1;
        state_nxt = restart_req ? S_RESTART : S_HALT;
      end
      default: begin
        state_nxt = restart_req ? S_RESTART : S_HALT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_HALT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The program memory survives a restart. Only the board reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (ld_valid && ld_ready) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign cpu_data  = mem[cpu_address];
  assign cpu_en    = en_raw & ~reset;
  assign cpu_reset = reset | (state == S_RESTART);
  assign ld_ready  = (state == S_HALT) & ~reset;
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_td4_exec_ctrl.sv
module tb_td4_exec_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       run_req, halt_req, step_req, restart_req;
  logic [3:0] rate;
  logic [3:0] cpu_address;
  logic [7:0] cpu_data;
  logic       cpu_en, cpu_reset;
  logic       ld_valid;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ready, halted;
`ifdef BREAKPOINT_EN
  logic       bp_enable;
  logic [3:0] bp_addr;
  logic       bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  td4_exec_ctrl #(.RATE_W(4)) dut (
    .clock(clock), .reset(reset),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .restart_req(restart_req), .rate(rate),
    .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready),
`ifdef BREAKPOINT_EN
    .bp_enable(bp_enable), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle. Inputs are then driven 2 time units after the edge,
  // and checks are made 3 time units after the edge.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; run_req = 0; halt_req = 0; step_req = 0; restart_req = 0;
    rate = 4'd0; cpu_address = 4'd0; ld_valid = 0; ld_addr = 0; ld_data = 0;
`ifdef BREAKPOINT_EN
    bp_enable = 1'b0; bp_addr = 4'd0;
`endif
    // Test 1: reset state and a cleared memory.
    cyc(); cyc(); #1;
    chk("rst_cpu_reset", {7'd0, cpu_reset}, 8'd1);
    chk("rst_cpu_en",    {7'd0, cpu_en},    8'd0);
    chk("rst_halted",    {7'd0, halted},    8'd1);
    chk("rst_ld_ready",  {7'd0, ld_ready},  8'd0);
    for (int a = 0; a < 16; a++) begin
      cpu_address = 4'(a); #1;
      chk("rst_mem", cpu_data, 8'h00);
    end
    reset = 1'b0;
    cyc(); #1;
    chk("post_rst_ld_ready",  {7'd0, ld_ready},  8'd1);
    chk("post_rst_cpu_reset", {7'd0, cpu_reset}, 8'd0);

    // Test 2: loader write in HALT.
    ld_valid = 1; ld_addr = 4'd3; ld_data = 8'hB5;
    cyc();
    ld_valid = 0; cpu_address = 4'd3; #1;
    chk("ld_write3", cpu_data, 8'hB5);
    cpu_address = 4'd4; #1;
    chk("ld_other4", cpu_data, 8'h00);

    // Test 3: rate=2. The request in cycle 0 gives ticks at 3 and 6. The halt in
    // cycle 7 halts at 8. The loader is held during RUN.
    rate = 4'd2; run_req = 1; #1;
    chk("run_c0_en", {7'd0, cpu_en}, 8'd0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      run_req = 0;
      halt_req = (c == 7);
      ld_valid = 1; ld_addr = 4'd3; ld_data = 8'h11;
      #1;
      chk($sformatf("run_en_c%0d", c), {7'd0, cpu_en}, {7'd0, (c == 3 || c == 6)});
      chk($sformatf("run_halted_c%0d", c), {7'd0, halted}, {7'd0, (c == 8)});
      if (c < 8) chk($sformatf("run_ld_ready_c%0d", c), {7'd0, ld_ready}, 8'd0);
    end
    halt_req = 0; ld_valid = 0; cpu_address = 4'd3; #1;
    chk("run_no_write", cpu_data, 8'hB5);

    // Test 4: a step and a run in the same cycle. Step has priority.
    cyc();
    step_req = 1; run_req = 1; #1;
    chk("step_c0_en", {7'd0, cpu_en}, 8'd0);
    cyc(); step_req = 0; run_req = 0; #1;
    chk("step_c1_en",     {7'd0, cpu_en}, 8'd1);
    chk("step_c1_halted", {7'd0, halted}, 8'd0);
    cyc(); #1;
    chk("step_c2_en",     {7'd0, cpu_en}, 8'd0);
    chk("step_c2_halted", {7'd0, halted}, 8'd1);
    cyc(); #1;
    chk("step_c3_en", {7'd0, cpu_en}, 8'd0);

    // Test 5: rate=0 RUN, then a restart and a halt in the same cycle.
    rate = 4'd0; run_req = 1;
    cyc(); run_req = 0; #1;
    chk("r0_c1_en", {7'd0, cpu_en}, 8'd1);
    cyc(); restart_req = 1; halt_req = 1; #1;
    chk("r0_c2_en", {7'd0, cpu_en}, 8'd1);
    cyc(); restart_req = 0; halt_req = 0; #1;
    chk("restart_cpu_reset", {7'd0, cpu_reset}, 8'd1);
    chk("restart_en",        {7'd0, cpu_en},    8'd0);
    chk("restart_halted",    {7'd0, halted},    8'd0);
    chk("restart_ld_ready",  {7'd0, ld_ready},  8'd0);
    cyc(); #1;
    chk("after_restart_cpu_reset", {7'd0, cpu_reset}, 8'd0);
    chk("after_restart_halted",    {7'd0, halted},    8'd1);
    chk("restart_mem_kept", cpu_data, 8'hB5);

    // A reset during RUN aborts and clears the memory.
    run_req = 1;
    cyc(); run_req = 0; #1;
    chk("pre_rst_en", {7'd0, cpu_en}, 8'd1);
    reset = 1; #1;
    chk("midrst_en",        {7'd0, cpu_en},    8'd0);
    chk("midrst_cpu_reset", {7'd0, cpu_reset}, 8'd1);
    chk("midrst_ld_ready",  {7'd0, ld_ready},  8'd0);
    cyc(); reset = 0; #1;
    chk("midrst_halted", {7'd0, halted}, 8'd1);
    chk("midrst_mem",    cpu_data,       8'h00);

`ifdef BREAKPOINT_EN
    // Test 6: the breakpoint at address 5 stops RUN. A resumed RUN executes
    // address 5, and reaching address 5 again stops RUN again.
    bp_enable = 1; bp_addr = 4'd5; rate = 4'd0; cpu_address = 4'd4; run_req = 1;
    cyc(); run_req = 0; #1;
    chk("bp_c1_en", {7'd0, cpu_en}, 8'd1);
    cyc(); cpu_address = 4'd5; #1;
    chk("bp_c2_en",  {7'd0, cpu_en}, 8'd0);
    chk("bp_c2_hit", {7'd0, bp_hit}, 8'd1);
    cyc(); run_req = 1; #1;
    chk("bp_c3_halted", {7'd0, halted}, 8'd1);
    cyc(); run_req = 0; #1;
    chk("bp_c4_en",  {7'd0, cpu_en}, 8'd1);
    chk("bp_c4_hit", {7'd0, bp_hit}, 8'd0);
    cyc(); cpu_address = 4'd6; #1;
    chk("bp_c5_en", {7'd0, cpu_en}, 8'd1);
    cyc(); cpu_address = 4'd5; #1;
    chk("bp_c6_hit", {7'd0, bp_hit}, 8'd1);
    chk("bp_c6_en",  {7'd0, cpu_en}, 8'd0);
    cyc(); #1;
    chk("bp_c7_halted", {7'd0, halted}, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
